eight_queen_checker: RTL and testbench

Solution-stream receiver for the eight-queen solver. It consumes the frames the solver presents on its `out_bus`/`done` outputs and reconstructs each board, one queen per beat. It then checks every board for column and diagonal conflicts and reports a one-cycle verdict per frame. It also counts the valid solutions received and records the solver's `no_answer` termination. It sits downstream of the solver in system and bench tops, as the consuming end of its result interface.

---
 rtl/eight_queen_checker.sv | 146 ++++++++++++++
 tb/tb_eight_queen_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/eight_queen_checker.sv
// eight_queen_checker: consumes the solver's result stream one row per beat,
// rebuilds each board, flags column/diagonal/shape errors and reports a
// one-cycle verdict per frame. Also counts good boards (saturating) and
// turns a rising edge of the solver's no_answer level into its own verdict.
module eight_queen_checker #(
    parameter  int N     = 8,
    parameter  int CNT_W = 8,
    localparam int W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sol_done,
    input  logic [N-1:0]       sol_bus,
    input  logic               sol_no_answer,
    output logic               result_valid,
    output logic               result_ok,
    output logic [3:0]         result_err,
    output logic               result_no_answer,
    output logic [N*W-1:0]     last_cols,
    output logic [CNT_W-1:0]   sol_count
);

    // Row counter holds 0..N+1; N+1 is sticky so over-long frames stay flagged.
    localparam int             RW      = $clog2(N + 2);
    localparam logic [RW-1:0]  ROW_N   = RW'(N);
    localparam logic [RW-1:0]  ROW_MAX = RW'(N + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, REPORT} state_t;

    state_t             state_reg;
    logic [N-1:0]       colm_reg, dmask_reg, amask_reg;
    logic [3:0]         err_reg;
    logic [RW-1:0]      row_reg;
    logic               na_prev_reg, na_pend_reg;

    logic               start_frame;
    logic [N-1:0]       base_colm, base_dmask, base_amask;
    logic [3:0]         base_err, beat_err, end_err;
    logic [RW-1:0]      base_row, row_next;
    logic [N-1:0]       colm_next, dmask_next, amask_next;
    logic [W-1:0]       beat_idx;
    logic               na_rise, na_req;

    assign na_rise = sol_no_answer & ~na_prev_reg;
    assign na_req  = na_pend_reg | na_rise;

    // Beat evaluation against either fresh masks (new frame) or the running ones.
    always_comb begin
        start_frame = (state_reg != CAPTURE);
        base_colm   = start_frame ? '0 : colm_reg;
        base_dmask  = start_frame ? '0 : dmask_reg;
        base_amask  = start_frame ? '0 : amask_reg;
        base_err    = start_frame ? '0 : err_reg;
        base_row    = start_frame ? '0 : row_reg;

        beat_err    = base_err | {(base_row >= ROW_N),
                                  |(sol_bus & (base_dmask | base_amask)),
                                  |(sol_bus & base_colm),
                                  ~$onehot(sol_bus)};
        colm_next   = base_colm | sol_bus;
        dmask_next  = (base_dmask | sol_bus) << 1;
        amask_next  = (base_amask | sol_bus) >> 1;
        row_next    = (base_row == ROW_MAX) ? base_row : base_row + 1'b1;
        end_err     = err_reg | {(row_reg != ROW_N), 3'b000};

        // Lowest set bit wins; an empty beat encodes as column 0.
        beat_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sol_bus[i]) beat_idx = W'(i);
        end
    end

    // Per-row column capture; rows past N-1 are never stored.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            logic [W-1:0] col_reg;
            // Latch this row's column whenever a beat lands on it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    col_reg <= '0;
                else if (sol_done && base_row == RW'(gi))
                    col_reg <= beat_idx;
            end
            assign last_cols[gi*W +: W] = col_reg;
        end
    endgenerate

    // Frame FSM with registered verdict outputs and no-answer deferral.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            colm_reg         <= '0;
            dmask_reg        <= '0;
            amask_reg        <= '0;
            err_reg          <= '0;
            row_reg          <= '0;
            na_prev_reg      <= 1'b0;
            na_pend_reg      <= 1'b0;
            result_valid     <= 1'b0;
            result_ok        <= 1'b0;
            result_err       <= '0;
            result_no_answer <= 1'b0;
            sol_count        <= '0;
        end else begin
            na_prev_reg  <= sol_no_answer;
            result_valid <= 1'b0;
            if (na_rise) na_pend_reg <= 1'b1;

            if (sol_done) begin
                // Any beat is absorbed, whatever state we are in.
                colm_reg  <= colm_next;
                dmask_reg <= dmask_next;
                amask_reg <= amask_next;
                err_reg   <= beat_err;
                row_reg   <= row_next;
                state_reg <= CAPTURE;
            end else begin
                case (state_reg)
                    CAPTURE: begin
                        err_reg          <= end_err;
                        result_valid     <= 1'b1;
                        result_ok        <= (end_err == 4'd0);
                        result_err       <= end_err;
                        result_no_answer <= 1'b0;
                        if (end_err == 4'd0 && sol_count != '1)
                            sol_count <= sol_count + 1'b1;
                        state_reg <= REPORT;
                    end
                    default: begin
                        if (na_req) begin
                            result_valid     <= 1'b1;
                            result_ok        <= 1'b0;
                            result_err       <= '0;
                            result_no_answer <= 1'b1;
                            na_pend_reg      <= 1'b0;
                            state_reg        <= REPORT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eight_queen_checker.sv
// Bench for eight_queen_checker: directed frames from the test plan plus
// random frames, checked against a pairwise-placement reference model.
module tb_eight_queen_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sol_done = 1'b0;
    logic [7:0]  sol_bus = '0;
    logic        sol_no_answer = 1'b0;
    logic        result_valid, result_ok, result_no_answer;
    logic [3:0]  result_err;
    logic [23:0] last_cols;
    logic [7:0]  sol_count;

    eight_queen_checker #(.N(8), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .sol_done(sol_done), .sol_bus(sol_bus),
        .sol_no_answer(sol_no_answer), .result_valid(result_valid),
        .result_ok(result_ok), .result_err(result_err),
        .result_no_answer(result_no_answer), .last_cols(last_cols),
        .sol_count(sol_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        na;
        logic        ok;
        logic [3:0]  err;
        logic [23:0] cols;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  fq[$];
    int          m_cols[8];
    int          m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_verdict = 0;
    logic [31:0] sols[4] = '{32'h04752613, 32'h05726314, 32'h13572064, 32'h73025164};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pack_cols();
        logic [23:0] v = '0;
        for (int r = 0; r < 8; r++) v[r*3 +: 3] = 3'(m_cols[r]);
        return v;
    endfunction

    // Load a frame of one-hot beats; row 0 is the top nibble of v.
    function automatic void load(input logic [31:0] v, input int len);
        fq.delete();
        for (int r = 0; r < len; r++) fq.push_back(8'd1 << v[31-4*r -: 4]);
    endfunction

    // Judge the frame in fq directly from queen geometry.
    function automatic void model_frame();
        exp_t       e;
        logic [3:0] err = '0;
        logic [7:0] used = '0;
        int         d;
        for (int j = 0; j < fq.size(); j++) begin
            if ($countones(fq[j]) != 1) err[0] = 1'b1;
            if ((fq[j] & used) != 0) err[1] = 1'b1;
            used |= fq[j];
            for (int i = 0; i < j; i++) begin
                d = j - i;
                for (int b = 0; b < 8; b++) begin
                    if (fq[i][b]) begin
                        if (b + d < 8 && fq[j][b+d]) err[2] = 1'b1;
                        if (b - d >= 0 && fq[j][b-d]) err[2] = 1'b1;
                    end
                end
            end
            if (j < 8) begin
                m_cols[j] = 0;
                for (int b = 7; b >= 0; b--) if (fq[j][b]) m_cols[j] = b;
            end
        end
        if (fq.size() != 8) err[3] = 1'b1;
        if (err == 0 && m_cnt < 255) m_cnt++;
        e.na = 1'b0; e.ok = (err == 0); e.err = err; e.cols = pack_cols(); e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endfunction

    function automatic void push_na();
        exp_t e;
        e.na = 1'b1; e.ok = 1'b0; e.err = '0; e.cols = pack_cols(); e.cnt = 8'(m_cnt);
        exp_q.push_back(e);
    endfunction

    // Drive fq as one frame; optionally raise no_answer at beat na_beat.
    task automatic send_frame(input int gap, input int na_beat);
        for (int i = 0; i < fq.size(); i++) begin
            @(posedge clk); #1;
            sol_done = 1'b1;
            sol_bus  = fq[i];
            if (i == na_beat) sol_no_answer = 1'b1;
        end
        @(posedge clk); #1;
        sol_done = 1'b0;
        sol_bus  = '0;
        model_frame();
        if (na_beat >= 0) push_na();
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int r = 0; r < 8; r++) m_cols[r] = 0;
    endtask

    // Verdict scoreboard: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && result_valid) begin
            n_verdict++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("verdict %0d: na=%0d ok=%0d err=%b cols=%h cnt=%0d",
                         n_verdict, result_no_answer, result_ok, result_err, last_cols, sol_count);
                check("na",   32'(result_no_answer), 32'(e.na));
                check("ok",   32'(result_ok),        32'(e.ok));
                check("err",  32'(result_err),       32'(e.err));
                check("cols", 32'(last_cols),        32'(e.cols));
                check("cnt",  32'(sol_count),        32'(e.cnt));
            end
        end
    end

    initial begin
        int mode, len, gap, c, tmp;
        int perm[8];
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(result_valid), 0);
        check("rst_ok",    32'(result_ok), 0);
        check("rst_err",   32'(result_err), 0);
        check("rst_na",    32'(result_no_answer), 0);
        check("rst_cols",  32'(last_cols), 0);
        check("rst_cnt",   32'(sol_count), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed frames
        load(32'h04752613, 8); send_frame(3, -1);   // legal
        load(32'h04752610, 8); send_frame(3, -1);   // column conflict
        load(32'h01475263, 8); send_frame(3, -1);   // diagonal conflict
        load(32'h04752613, 5); send_frame(3, -1);   // short
        load(32'h05726314, 8); fq.push_back(8'h04); send_frame(3, -1); // 9 beats
        load(32'h04752613, 8); fq[3] = 8'h00; send_frame(3, -1);
        load(32'h13572064, 8); fq[6] = 8'h81; send_frame(3, -1);
        load(32'h04752613, 8); send_frame(1, -1);   // back-to-back
        load(32'h04752610, 8); send_frame(1, -1);
        load(32'h05726314, 8); send_frame(3, -1);

        // no_answer in IDLE
        @(posedge clk); #1; sol_no_answer = 1'b1; push_na();
        repeat (4) @(posedge clk); #1; sol_no_answer = 1'b0;
        repeat (2) @(posedge clk);
        // no_answer rising mid-frame
        load(32'h13572064, 8); send_frame(4, 4);
        #1; sol_no_answer = 1'b0;
        repeat (2) @(posedge clk);

        // Random frames
        for (int f = 0; f < 150; f++) begin
            mode = $urandom_range(0, 3);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 10) : 8;
            fq.delete();
            if (mode == 0) begin
                load(sols[$urandom_range(0, 3)], (len > 8) ? 8 : len);
            end else if (mode == 1) begin
                for (int i = 0; i < 8; i++) perm[i] = i;
                for (int i = 7; i > 0; i--) begin
                    c = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[c]; perm[c] = tmp;
                end
                for (int i = 0; i < len; i++) fq.push_back(8'd1 << perm[i % 8]);
            end else if (mode == 2) begin
                for (int i = 0; i < len; i++) fq.push_back(8'd1 << $urandom_range(0, 7));
            end else begin
                for (int i = 0; i < len; i++) fq.push_back(8'($urandom_range(0, 255)));
            end
            gap = $urandom_range(1, 3);
            send_frame(gap, -1);
        end
        repeat (3) @(posedge clk);

        // Reset in the middle of a frame
        load(32'h04752613, 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; sol_done = 1'b1; sol_bus = fq[i];
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(result_valid), 0);
        check("mid_rst_ok",    32'(result_ok), 0);
        check("mid_rst_err",   32'(result_err), 0);
        check("mid_rst_na",    32'(result_no_answer), 0);
        check("mid_rst_cols",  32'(last_cols), 0);
        check("mid_rst_cnt",   32'(sol_count), 0);
        sol_done = 1'b0; sol_bus = '0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Counter saturation
        for (int f = 0; f < 260; f++) begin
            load(sols[f % 4], 8);
            send_frame(1, -1);
        end

        repeat (20) @(posedge clk);
        check("drain", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
